// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared types and constants for the Sobel window controller:
//            default pixel width, controller state encoding and the row-major
//            index of each tap in the 3x3 window.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  localparam int SOBEL_PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Window taps, row-major: top row 0..2, middle row 3..5, bottom row 6..8
  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Purpose  : Single-clock line store, DEPTH entries of WIDTH bits. The read
//            port is asynchronous so the same address can be read and then
//            overwritten on one edge (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the new column entry; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_ctrl
// Purpose  : Frame sequencer for the Sobel filter. Accepts a raster pixel
//            stream, keeps two rows in a line buffer, presents the 3x3
//            neighbourhood to the filter and re-times the filter output into
//            a result stream with valid and done flags.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIX_W    = SOBEL_PIX_W,
  parameter int FILT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] win0,
  output logic [PIX_W-1:0] win1,
  output logic [PIX_W-1:0] win2,
  output logic [PIX_W-1:0] win3,
  output logic [PIX_W-1:0] win4,
  output logic [PIX_W-1:0] win5,
  output logic [PIX_W-1:0] win6,
  output logic [PIX_W-1:0] win7,
  output logic [PIX_W-1:0] win8,
  output logic             refresh,
  input  logic [PIX_W-1:0] filt_out,
  output logic [PIX_W-1:0] res_data,
  output logic             res_valid,
  output logic             busy,
  output logic             done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = $clog2(FILT_LAT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [DW-1:0]       dcnt;
  logic [PIX_W-1:0]    win [9];
  logic [FILT_LAT-1:0] vpipe;
  logic [2*PIX_W-1:0]  lb_rd;
  logic [2*PIX_W-1:0]  lb_wr;
  logic                accept;
  logic                at_last;
  logic                at_first_win;
  logic                win_ok;

  assign accept       = pix_valid & pix_ready;
  assign at_last      = (x == X_LAST) && (y == Y_LAST);
  assign at_first_win = (x == XW'(2)) && (y == YW'(2));
  // Column gating alone keeps previous-row columns out of valid windows
  assign win_ok       = (x >= XW'(2)) && (y >= YW'(2));

  // Both lines share one buffer: upper half is the older row (linebuf1)
  assign lb_wr = {lb_rd[PIX_W-1:0], pix_in};

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2*PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  // Frame sequencer with registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      refresh   <= 1'b0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            refresh <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          refresh   <= 1'b0;
          pix_ready <= 1'b1;
          state     <= FILL;
        end
        FILL, RUN: begin
          if (accept) begin
            if (at_last) begin
              state     <= DRAIN;
              pix_ready <= 1'b0;
              dcnt      <= '0;
            end else if (state == FILL && at_first_win) begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          // Hold until the last window's result has been registered
          if (dcnt == DW'(FILT_LAT)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (state == CLEAR) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Shift the window one column left and load the new right column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[W_TL] <= win[W_TC];
      win[W_TC] <= win[W_TR];
      win[W_TR] <= lb_rd[2*PIX_W-1:PIX_W];
      win[W_ML] <= win[W_MC];
      win[W_MC] <= win[W_MR];
      win[W_MR] <= lb_rd[PIX_W-1:0];
      win[W_BL] <= win[W_BC];
      win[W_BC] <= win[W_BR];
      win[W_BR] <= pix_in;
    end
  end

  // Track window validity through the filter latency and capture results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      vpipe[0] <= accept & win_ok;
      for (int i = 1; i < FILT_LAT; i++) vpipe[i] <= vpipe[i-1];
      res_valid <= vpipe[FILT_LAT-1];
      if (vpipe[FILT_LAT-1]) res_data <= filt_out;
    end
  end

  assign win0 = win[W_TL];
  assign win1 = win[W_TC];
  assign win2 = win[W_TR];
  assign win3 = win[W_ML];
  assign win4 = win[W_MC];
  assign win5 = win[W_MR];
  assign win6 = win[W_BL];
  assign win7 = win[W_BC];
  assign win8 = win[W_BR];

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_ctrl
// Purpose  : Self-checking bench for sobel_window_ctrl. Two instances share
//            the stimulus, one with filter latency 1 and one with latency 3.
//            Each sees a filter model returning the centre tap, delayed so
//            its output is valid FILT_LAT cycles after the window load.
//            Expected results come from the frame image held in the bench.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sobel_window_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PW   = 8;
  localparam int NRES = (W-2)*(H-2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [PW-1:0] pix_in;

  logic          pr1, rf1, rv1, bz1, dn1;
  logic [PW-1:0] w1 [9];
  logic [PW-1:0] fo1, rd1;
  logic          pr3, rf3, rv3, bz3, dn3;
  logic [PW-1:0] w3 [9];
  logic [PW-1:0] fo3, rd3;
  logic [PW-1:0] f3a, f3b;

  int n_cmp, n_err, cyc;
  int img [W*H];
  int exp_q1 [$];
  int exp_q3 [$];
  int tq1 [$];
  int tq3 [$];
  int bx, by, px, py;
  int res_cnt1, res_cnt3, done_cnt1, done_cnt3, ref_cnt;
  int last_res1, last_res3;
  bit prev_done1, prev_done3, acc_prev, pend_win, snap_ok;
  logic [PW-1:0] snap [9];

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .FILT_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr1), .win0(w1[0]), .win1(w1[1]), .win2(w1[2]), .win3(w1[3]),
    .win4(w1[4]), .win5(w1[5]), .win6(w1[6]), .win7(w1[7]), .win8(w1[8]),
    .refresh(rf1), .filt_out(fo1), .res_data(rd1), .res_valid(rv1),
    .busy(bz1), .done(dn1)
  );

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .FILT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr3), .win0(w3[0]), .win1(w3[1]), .win2(w3[2]), .win3(w3[3]),
    .win4(w3[4]), .win5(w3[5]), .win6(w3[6]), .win7(w3[7]), .win8(w3[8]),
    .refresh(rf3), .filt_out(fo3), .res_data(rd3), .res_valid(rv3),
    .busy(bz3), .done(dn3)
  );

  // Filter models: centre tap, total latency FILT_LAT from window load
  assign fo1 = w1[4];
  always @(posedge clk) begin
    f3a <= w3[4];
    f3b <= f3a;
  end
  assign fo3 = f3b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle monitor: window contents, result timing/data, done and busy
  always @(negedge clk) begin
    if (rst) begin
      exp_q1.delete(); exp_q3.delete(); tq1.delete(); tq3.delete();
      bx = 0; by = 0; acc_prev = 0; pend_win = 0; snap_ok = 0;
      prev_done1 = 0; prev_done3 = 0;
    end else begin
      if (acc_prev && pend_win) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            check("win_tap", w1[r*3+c], img[(py-2+r)*W + (px-2+c)]);
      end else if (!acc_prev && snap_ok) begin
        for (int k = 0; k < 9; k++) check("win_hold", w1[k], snap[k]);
      end
      for (int k = 0; k < 9; k++) snap[k] = w1[k];
      snap_ok = 1;

      check("ready_match", pr3, pr1);
      acc_prev = pix_valid && pr1;
      pend_win = 0;
      if (acc_prev) begin
        if (bx >= 2 && by >= 2) begin
          tq1.push_back(cyc + 2);
          tq3.push_back(cyc + 4);
          pend_win = 1; px = bx; py = by;
        end
        if (bx == W-1) begin bx = 0; by = (by == H-1) ? 0 : by + 1; end
        else bx = bx + 1;
      end

      if (tq1.size() > 0 && tq1[0] == cyc) begin
        check("res1_valid", rv1, 1);
        void'(tq1.pop_front());
        if (exp_q1.size() > 0) check("res1_data", rd1, exp_q1.pop_front());
      end else if (rv1) begin
        check("res1_spurious", rv1, 0);
      end
      if (tq3.size() > 0 && tq3[0] == cyc) begin
        check("res3_valid", rv3, 1);
        void'(tq3.pop_front());
        if (exp_q3.size() > 0) check("res3_data", rd3, exp_q3.pop_front());
      end else if (rv3) begin
        check("res3_spurious", rv3, 0);
      end
      if (rv1) begin res_cnt1++; last_res1 = cyc; end
      if (rv3) begin res_cnt3++; last_res3 = cyc; end

      if (dn1) begin done_cnt1++; check("done1_time", cyc, last_res1 + 1); end
      if (dn3) begin done_cnt3++; check("done3_time", cyc, last_res3 + 1); end
      if (prev_done1) check("busy1_fall", bz1, 0);
      if (prev_done3) check("busy3_fall", bz3, 0);
      prev_done1 = dn1;
      prev_done3 = dn3;
      if (rf1) ref_cnt++;
    end
  end

  task automatic clear_counts();
    res_cnt1 = 0; res_cnt3 = 0; done_cnt1 = 0; done_cnt3 = 0; ref_cnt = 0;
  endtask

  task automatic load_image(input int mode);
    for (int i = 0; i < W*H; i++) img[i] = (mode == 2) ? int'($urandom_range(0, 255)) : i;
    for (int cy = 1; cy < H-1; cy++)
      for (int cx = 1; cx < W-1; cx++) begin
        exp_q1.push_back(img[cy*W + cx]);
        exp_q3.push_back(img[cy*W + cx]);
      end
  endtask

  // Stream pixels until 'limit' have been accepted; mode 0 solid, 1 alternate, 2 random
  task automatic stream(input int mode, input bit poke, input int limit);
    int  idx;
    int  guard;
    bit  acc;
    idx = 0; guard = 0;
    while (idx < limit && guard < 400) begin
      case (mode)
        1:       pix_valid = (guard % 2) == 0;
        2:       pix_valid = $urandom_range(0, 2) != 0;
        default: pix_valid = 1'b1;
      endcase
      pix_in = img[idx][PW-1:0];
      start  = poke && (idx == 12);
      @(negedge clk);
      acc = pix_valid && pr1;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    check("stream_count", idx, limit);
  endtask

  task automatic run_frame(input int mode, input bit poke);
    int guard;
    clear_counts();
    load_image(mode);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream(mode, poke, W*H);
    guard = 0;
    while (done_cnt3 == 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("n_res1", res_cnt1, NRES);
    check("n_res3", res_cnt3, NRES);
    check("n_done1", done_cnt1, 1);
    check("n_done3", done_cnt3, 1);
    check("n_refresh", ref_cnt, 1);
    check("busy1_end", bz1, 0);
    check("busy3_end", bz3, 0);
    check("exp1_left", exp_q1.size(), 0);
    check("exp3_left", exp_q3.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready1"}, pr1, 0);
    check({tag, "_busy1"}, bz1, 0);
    check({tag, "_done1"}, dn1, 0);
    check({tag, "_refresh1"}, rf1, 0);
    check({tag, "_rvalid1"}, rv1, 0);
    check({tag, "_rdata1"}, rd1, 0);
    check({tag, "_win4_1"}, w1[4], 0);
    check({tag, "_busy3"}, bz3, 0);
    check({tag, "_rvalid3"}, rv3, 0);
    check({tag, "_ready3"}, pr3, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    for (int i = 0; i < W*H; i++) img[i] = i;
    clear_counts();
    last_res1 = 0; last_res3 = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("idle");

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);

    // Abort a ramp frame after nine accepted pixels
    clear_counts();
    load_image(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream(0, 1'b0, 9);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    repeat (4) run_frame(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
